// File: rtl/seq_unit_if.sv
// ---------------------------------------------------------------------------
// seq_unit_if : instruction/register bus of the microprogram sequencer.
//
// Purpose : bundles the instruction fetch, input-register and output-register
//           signals of seq_unit so that the controller side (master) and the
//           sequencer (slave) connect through a single port.
//
// Signals
//   inst      12  instruction: [11:8] opcode, [7:0] immediate/operand field
//   inst_en    1  instruction valid; 0 makes the cycle a no-op
//   ireg_0..3  8  input registers, selected by inst[5:4]
//   next       8  program counter (address of the next instruction)
//   oreg      12  output data word
//   oreg_wen   8  one-hot output register write enable (single-cycle pulse)
//   error      1  only when SEQ_ERROR_OUT_EN is defined: 1 while in ERROR
//
// Modports
//   master : drives inst/inst_en/ireg_*, observes the sequencer outputs
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface seq_unit_if;
    logic [11:0] inst;
    logic        inst_en;
    logic [7:0]  ireg_0;
    logic [7:0]  ireg_1;
    logic [7:0]  ireg_2;
    logic [7:0]  ireg_3;
    logic [7:0]  next;
    logic [11:0] oreg;
    logic [7:0]  oreg_wen;
`ifdef SEQ_ERROR_OUT_EN
    logic        error;
`endif

`ifdef SEQ_ERROR_OUT_EN
    modport master (
        output inst, inst_en, ireg_0, ireg_1, ireg_2, ireg_3,
        input  next, oreg, oreg_wen, error
    );
    modport slave (
        input  inst, inst_en, ireg_0, ireg_1, ireg_2, ireg_3,
        output next, oreg, oreg_wen, error
    );
`else
    modport master (
        output inst, inst_en, ireg_0, ireg_1, ireg_2, ireg_3,
        input  next, oreg, oreg_wen
    );
    modport slave (
        input  inst, inst_en, ireg_0, ireg_1, ireg_2, ireg_3,
        output next, oreg, oreg_wen
    );
`endif
endinterface

// File: rtl/seq_unit.sv
// ---------------------------------------------------------------------------
// seq_unit : microprogram sequencer.
//
// Purpose : executes one 12-bit instruction per clock from an external
//           instruction store addressed by the registered program counter
//           `next`. Holds an 8-bit accumulator, reads four 8-bit input
//           registers and writes 12-bit words to eight output registers via
//           one-hot write enables.
//
// Ports
//   clock  in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   bus    slave modport of seq_unit_if (inst, inst_en, ireg_0..3 in;
//               next, oreg, oreg_wen [, error] out)
//
// Configuration
//   SEQ_ERROR_OUT_EN : when defined, bus.error is driven (registered, 1 exactly
//                      while in ERROR). When undefined the ERROR state is only
//                      visible through the frozen program counter.
//
// All outputs come straight from registers. An invalid opcode (B..F) sampled
// with inst_en=1 locks the sequencer in ERROR until reset.
// ---------------------------------------------------------------------------
module seq_unit (
    input  logic       clock,
    input  logic       reset,
    seq_unit_if.slave  bus
);

    localparam logic [0:0] ST_READY = 1'b0;
    localparam logic [0:0] ST_ERROR = 1'b1;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDR = 4'h2;
    localparam logic [3:0] OP_CMD = 4'h3;
    localparam logic [3:0] OP_DMP = 4'h4;
    localparam logic [3:0] OP_EQI = 4'h5;
    localparam logic [3:0] OP_EQR = 4'h6;
    localparam logic [3:0] OP_JXI = 4'h7;
    localparam logic [3:0] OP_JXR = 4'h8;
    localparam logic [3:0] OP_JZI = 4'h9;
    localparam logic [3:0] OP_JZR = 4'hA;

    // One-hot decode of the 3-bit output register index.
    function automatic logic [7:0] onehot8(input logic [2:0] k);
        onehot8 = 8'h01 << k;
    endfunction

    logic [0:0]  r_state;
    logic [7:0]  r_next;
    logic [7:0]  r_acc;
    logic [11:0] r_oreg;
    logic [7:0]  r_wen;

    logic [3:0]  w_op;
    logic [7:0]  w_imm;
    logic [7:0]  w_reg;
    logic [7:0]  w_pc_inc;
    logic        w_acc_zero;
    logic [0:0]  w_state_nxt;
    logic [7:0]  w_next_nxt;
    logic [7:0]  w_acc_nxt;
    logic [11:0] w_oreg_nxt;
    logic [7:0]  w_wen_nxt;

    assign w_op       = bus.inst[11:8];
    assign w_imm      = bus.inst[7:0];
    assign w_pc_inc   = r_next + 8'd1;
    assign w_acc_zero = (r_acc == 8'h00);

    // Input register selection by inst[5:4].
    always_comb begin
        w_reg = 8'h00;
        case (bus.inst[5:4])
            2'd0:    w_reg = bus.ireg_0;
            2'd1:    w_reg = bus.ireg_1;
            2'd2:    w_reg = bus.ireg_2;
            2'd3:    w_reg = bus.ireg_3;
            default: w_reg = 8'h00;
        endcase
    end

    // Instruction decode and next-state computation.
    always_comb begin
        w_state_nxt = r_state;
        w_next_nxt  = r_next;
        w_acc_nxt   = r_acc;
        w_oreg_nxt  = r_oreg;
        w_wen_nxt   = 8'h00;
        if ((r_state == ST_READY) && bus.inst_en) begin
            w_next_nxt = w_pc_inc;
            case (w_op)
                OP_NOP: begin
                    w_next_nxt = w_pc_inc;
                end
                OP_LDI: begin
                    w_acc_nxt = w_imm;
                end
                OP_LDR: begin
                    w_acc_nxt = w_reg;
                end
                OP_CMD: begin
                    w_oreg_nxt = {w_imm[7:4], r_acc};
                    w_wen_nxt  = onehot8(bus.inst[2:0]);
                end
                OP_DMP: begin
                    w_oreg_nxt = {4'h0, r_acc};
                    w_wen_nxt  = onehot8(bus.inst[2:0]);
                end
                OP_EQI: begin
                    w_acc_nxt = (r_acc == w_imm) ? 8'h01 : 8'h00;
                end
                OP_EQR: begin
                    w_acc_nxt = (r_acc == w_reg) ? 8'h01 : 8'h00;
                end
                OP_JXI: begin
                    w_next_nxt = w_imm;
                end
                OP_JXR: begin
                    w_next_nxt = w_reg;
                end
                OP_JZI: begin
                    w_next_nxt = w_acc_zero ? w_imm : w_pc_inc;
                end
                OP_JZR: begin
                    w_next_nxt = w_acc_zero ? w_reg : w_pc_inc;
                end
                default: begin
                    // Invalid opcode: freeze everything and lock up.
                    w_state_nxt = ST_ERROR;
                    w_next_nxt  = r_next;
                end
            endcase
        end else begin
            // Idle cycle or ERROR: hold state, no write pulse.
            w_wen_nxt = 8'h00;
        end
    end

    // State and output registers; reset overrides any instruction.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_READY;
            r_next  <= 8'h00;
            r_acc   <= 8'h00;
            r_oreg  <= 12'h000;
            r_wen   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_next  <= w_next_nxt;
            r_acc   <= w_acc_nxt;
            r_oreg  <= w_oreg_nxt;
            r_wen   <= w_wen_nxt;
        end
    end

    assign bus.next     = r_next;
    assign bus.oreg     = r_oreg;
    assign bus.oreg_wen = r_wen;

`ifdef SEQ_ERROR_OUT_EN
    logic r_error;

    // Registered error flag tracking entry into ERROR.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_error <= 1'b0;
        end else begin
            r_error <= (w_state_nxt == ST_ERROR);
        end
    end

    assign bus.error = r_error;
`endif

endmodule

// File: tb/tb_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_unit : self-checking bench for seq_unit.
// A vector table of {reset, inst_en, inst, ireg_0..3, expected next/oreg/wen/
// error} drives the design; expected results are queued when a vector is
// driven and popped after the clock edge that executes it. The ERROR lock-up
// and reset recovery are exercised by a hand-written sequence.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_unit;

    typedef struct {
        logic        rst;
        logic        en;
        logic [11:0] inst;
        logic [7:0]  ir0;
        logic [7:0]  ir1;
        logic [7:0]  ir2;
        logic [7:0]  ir3;
        logic [7:0]  e_next;
        logic [11:0] e_oreg;
        logic [7:0]  e_wen;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [7:0]  e_next;
        logic [11:0] e_oreg;
        logic [7:0]  e_wen;
        logic        e_err;
        int          idx;
    } exp_t;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    exp_t exp_q[$];
    vec_t tbl[$];

    seq_unit_if u_if();

    seq_unit u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int idx, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic en, input logic [11:0] inst,
                                input logic [7:0] ir0, input logic [7:0] ir1,
                                input logic [7:0] ir2, input logic [7:0] ir3,
                                input logic [7:0] e_next, input logic [11:0] e_oreg,
                                input logic [7:0] e_wen, input logic e_err);
        vec_t v;
        v.rst = rst; v.en = en; v.inst = inst;
        v.ir0 = ir0; v.ir1 = ir1; v.ir2 = ir2; v.ir3 = ir3;
        v.e_next = e_next; v.e_oreg = e_oreg; v.e_wen = e_wen; v.e_err = e_err;
        return v;
    endfunction

    // Drive one vector, queue its expectation, clock it and compare.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        reset        = v.rst;
        u_if.inst_en = v.en;
        u_if.inst    = v.inst;
        u_if.ireg_0  = v.ir0;
        u_if.ireg_1  = v.ir1;
        u_if.ireg_2  = v.ir2;
        u_if.ireg_3  = v.ir3;
        e.e_next = v.e_next; e.e_oreg = v.e_oreg; e.e_wen = v.e_wen;
        e.e_err = v.e_err; e.idx = idx;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard step %0d: queue empty", idx);
        end else begin
            got = exp_q.pop_front();
            chk("next", got.idx, {4'h0, u_if.next}, {4'h0, got.e_next});
            chk("oreg", got.idx, u_if.oreg, got.e_oreg);
            chk("oreg_wen", got.idx, {4'h0, u_if.oreg_wen}, {4'h0, got.e_wen});
`ifdef SEQ_ERROR_OUT_EN
            chk("error", got.idx, {11'h000, u_if.error}, {11'h000, got.e_err});
`endif
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;

        // Main program: {rst, en, inst, ireg0..3, next, oreg, wen, err}
        tbl.push_back(mk(1'b1, 1'b0, 12'h000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 12'h000, 8'h00, 1'b0)); // reset
        tbl.push_back(mk(1'b0, 1'b1, 12'h1FA, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h01, 12'h000, 8'h00, 1'b0)); // LDI FA
        tbl.push_back(mk(1'b0, 1'b1, 12'h000, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h02, 12'h000, 8'h00, 1'b0)); // NOP
        tbl.push_back(mk(1'b0, 1'b1, 12'h400, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h03, 12'h0FA, 8'h01, 1'b0)); // DMP 0
        tbl.push_back(mk(1'b0, 1'b1, 12'h210, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h04, 12'h0FA, 8'h00, 1'b0)); // LDR ireg_1
        tbl.push_back(mk(1'b0, 1'b1, 12'h324, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h05, 12'h2AA, 8'h10, 1'b0)); // CMD 24
        tbl.push_back(mk(1'b0, 1'b1, 12'h402, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h06, 12'h0AA, 8'h04, 1'b0)); // DMP 2
        tbl.push_back(mk(1'b0, 1'b1, 12'h000, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h07, 12'h0AA, 8'h00, 1'b0)); // NOP
        tbl.push_back(mk(1'b0, 1'b1, 12'h5AA, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h08, 12'h0AA, 8'h00, 1'b0)); // EQI AA
        tbl.push_back(mk(1'b0, 1'b1, 12'h400, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h09, 12'h001, 8'h01, 1'b0)); // DMP -> 01
        tbl.push_back(mk(1'b0, 1'b1, 12'h1BB, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h0A, 12'h001, 8'h00, 1'b0)); // LDI BB
        tbl.push_back(mk(1'b0, 1'b1, 12'h5AA, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h0B, 12'h001, 8'h00, 1'b0)); // EQI AA
        tbl.push_back(mk(1'b0, 1'b1, 12'h401, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h0C, 12'h000, 8'h02, 1'b0)); // DMP -> 00
        tbl.push_back(mk(1'b0, 1'b1, 12'h1AA, 8'h00, 8'hAA, 8'hAA, 8'h00, 8'h0D, 12'h000, 8'h00, 1'b0)); // LDI AA
        tbl.push_back(mk(1'b0, 1'b1, 12'h620, 8'h00, 8'hAA, 8'hAA, 8'h00, 8'h0E, 12'h000, 8'h00, 1'b0)); // EQR ireg_2
        tbl.push_back(mk(1'b0, 1'b1, 12'h407, 8'h00, 8'hAA, 8'hAA, 8'h00, 8'h0F, 12'h001, 8'h80, 1'b0)); // DMP 7 -> 01
        tbl.push_back(mk(1'b0, 1'b1, 12'h71A, 8'h00, 8'hAA, 8'hAA, 8'h00, 8'h1A, 12'h001, 8'h00, 1'b0)); // JXI 1A
        tbl.push_back(mk(1'b0, 1'b1, 12'h820, 8'h00, 8'hAA, 8'h2A, 8'h00, 8'h2A, 12'h001, 8'h00, 1'b0)); // JXR ireg_2
        tbl.push_back(mk(1'b0, 1'b1, 12'h100, 8'h00, 8'hAA, 8'h2A, 8'h00, 8'h2B, 12'h001, 8'h00, 1'b0)); // LDI 00
        tbl.push_back(mk(1'b0, 1'b1, 12'h93A, 8'h00, 8'hAA, 8'h2A, 8'h00, 8'h3A, 12'h001, 8'h00, 1'b0)); // JZI taken
        tbl.push_back(mk(1'b0, 1'b1, 12'h101, 8'h00, 8'hAA, 8'h2A, 8'h00, 8'h3B, 12'h001, 8'h00, 1'b0)); // LDI 01
        tbl.push_back(mk(1'b0, 1'b1, 12'h94A, 8'h00, 8'hAA, 8'h2A, 8'h00, 8'h3C, 12'h001, 8'h00, 1'b0)); // JZI fall
        tbl.push_back(mk(1'b0, 1'b1, 12'hA30, 8'h00, 8'hAA, 8'h2A, 8'h55, 8'h3D, 12'h001, 8'h00, 1'b0)); // JZR fall
        tbl.push_back(mk(1'b0, 1'b1, 12'h100, 8'h00, 8'hAA, 8'h2A, 8'h55, 8'h3E, 12'h001, 8'h00, 1'b0)); // LDI 00
        tbl.push_back(mk(1'b0, 1'b1, 12'hA30, 8'h00, 8'hAA, 8'h2A, 8'h77, 8'h77, 12'h001, 8'h00, 1'b0)); // JZR taken
        tbl.push_back(mk(1'b0, 1'b1, 12'h7FF, 8'h00, 8'hAA, 8'h2A, 8'h77, 8'hFF, 12'h001, 8'h00, 1'b0)); // JXI FF
        tbl.push_back(mk(1'b0, 1'b1, 12'h000, 8'h00, 8'hAA, 8'h2A, 8'h77, 8'h00, 12'h001, 8'h00, 1'b0)); // NOP wrap
        tbl.push_back(mk(1'b0, 1'b0, 12'h1CC, 8'h00, 8'hAA, 8'h2A, 8'h77, 8'h00, 12'h001, 8'h00, 1'b0)); // idle
        tbl.push_back(mk(1'b0, 1'b0, 12'h4FF, 8'h00, 8'hAA, 8'h2A, 8'h77, 8'h00, 12'h001, 8'h00, 1'b0)); // idle
        tbl.push_back(mk(1'b0, 1'b1, 12'h403, 8'h00, 8'hAA, 8'h2A, 8'h77, 8'h01, 12'h000, 8'h08, 1'b0)); // DMP 3
        tbl.push_back(mk(1'b0, 1'b1, 12'b0010_xx01_xxxx, 8'h00, 8'h3C, 8'h2A, 8'h77, 8'h02, 12'h000, 8'h00, 1'b0)); // LDR, X operands
        tbl.push_back(mk(1'b0, 1'b1, 12'b0100_xxxx_x101, 8'h00, 8'h3C, 8'h2A, 8'h77, 8'h03, 12'h03C, 8'h20, 1'b0)); // DMP 5

        reset = 1'b1;
        u_if.inst_en = 1'b0;
        u_if.inst = 12'h000;
        u_if.ireg_0 = 8'h00; u_if.ireg_1 = 8'h00; u_if.ireg_2 = 8'h00; u_if.ireg_3 = 8'h00;
        @(posedge clock);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // ERROR lock-up and recovery through reset.
        apply(mk(1'b0, 1'b1, 12'hF02, 8'h00, 8'h3C, 8'h2A, 8'h77, 8'h03, 12'h03C, 8'h00, 1'b1), 100); // invalid
        apply(mk(1'b0, 1'b1, 12'h510, 8'h00, 8'h3C, 8'h2A, 8'h77, 8'h03, 12'h03C, 8'h00, 1'b1), 101); // EQI ignored
        apply(mk(1'b0, 1'b1, 12'h400, 8'h00, 8'h3C, 8'h2A, 8'h77, 8'h03, 12'h03C, 8'h00, 1'b1), 102); // DMP ignored
        apply(mk(1'b0, 1'b1, 12'h7AA, 8'h00, 8'h3C, 8'h2A, 8'h77, 8'h03, 12'h03C, 8'h00, 1'b1), 103); // JXI ignored
        apply(mk(1'b1, 1'b1, 12'h1FF, 8'h00, 8'h3C, 8'h2A, 8'h77, 8'h00, 12'h000, 8'h00, 1'b0), 104); // reset wins
        apply(mk(1'b0, 1'b1, 12'h1FF, 8'h00, 8'h3C, 8'h2A, 8'h77, 8'h01, 12'h000, 8'h00, 1'b0), 105); // LDI FF
        apply(mk(1'b0, 1'b1, 12'h000, 8'h00, 8'h3C, 8'h2A, 8'h77, 8'h02, 12'h000, 8'h00, 1'b0), 106); // NOP
        apply(mk(1'b0, 1'b1, 12'h400, 8'h00, 8'h3C, 8'h2A, 8'h77, 8'h03, 12'h0FF, 8'h01, 1'b0), 107); // DMP -> FF
        apply(mk(1'b0, 1'b1, 12'h5FF, 8'h00, 8'h3C, 8'h2A, 8'h77, 8'h04, 12'h0FF, 8'h00, 1'b0), 108); // EQI FF
        apply(mk(1'b0, 1'b1, 12'h3F6, 8'h00, 8'h3C, 8'h2A, 8'h77, 8'h05, 12'hF01, 8'h40, 1'b0), 109); // CMD F6

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end
        checks++;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
